uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1 by default. Samples the serial line on the 16x oversampling tick
//  from baudrate_generator (o_tick -> i_tick). Reconstructs each frame LSB-first.
//  Presents the parallel byte with a one-cycle done strobe to the consuming logic.
//  Flags framing errors (bad stop bit).
// PARAMETERS
//  DATA_BITS  8   data bits per frame
//  SAMPLING   16  ticks per bit; must match baudrate_generator SAMPLING; even, >=4
//  SB_TICKS   16  ticks spent in stop bit (16 = 1 stop bit, 32 = 2)
// PORTS
//  i_clk        in   1          system clock
//  i_reset      in   1          asynchronous reset, active-high
//  i_tick       in   1          oversampling tick, 1-cycle pulse from baudrate_generator
//  i_rx         in   1          serial line; idle high; asynchronous to i_clk
//  o_data       out  DATA_BITS  last received byte; held until next o_rx_done
//  o_rx_done    out  1          1-cycle strobe: o_data/o_frame_err valid
//  o_frame_err  out  1          stop bit sampled 0; updated with o_rx_done, held
//  o_parity_err out  1          present only with UART_RX_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, shift reg 0, sync flops 1; all outputs 0.
//  - i_rx passes through 2-FF synchronizer (rx_s); FSM sees rx_s, 2 clk latency.
//  - Counters: s (tick count, width clog2(max(SAMPLING,SB_TICKS))), n (bit index).
//  - s advances only on cycles with i_tick=1; all transitions below except
//    IDLE->START occur on tick cycles.
//  - IDLE: rx_s==0 (any cycle) -> START, s<=0. i_tick ignored.
//  - START: tick && s==SAMPLING/2-1 -> mid-start-bit sample:
//    rx_s==0 -> DATA, s<=0, n<=0; rx_s==1 -> IDLE (glitch reject, no strobe).
//    Else tick -> s<=s+1.
//  - DATA: tick && s==SAMPLING-1 -> s<=0, b<={rx_s,b[DATA_BITS-1:1]} (LSB first);
//    n==DATA_BITS-1 -> STOP (or PARITY), else n<=n+1. Else tick -> s++.
//    Samples therefore land at bit centres.
//  - STOP: tick && s==SB_TICKS-1 -> IDLE.
//    Same cycle, registered outputs: o_data<=b, o_frame_err<=~rx_s, o_rx_done<=1.
//    Else tick -> s++.
//  - o_rx_done high exactly 1 clk per accepted frame, never on glitch-rejected starts.
//  - Back-to-back: STOP ends mid stop bit, so a start edge immediately following a
//    stop bit is caught; no idle gap required.
//  - Line held low (break): frame with o_data=0, o_frame_err=1.
//    Then IDLE re-enters START at once and repeats while low.
//  - Reset mid-frame: immediate return to IDLE; the partial frame is discarded.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - PARITY state inserted between DATA and STOP; sampled at s==SAMPLING-1 like data.
//    - Even parity: o_parity_err <= ^{b, parity_bit}, updated with o_rx_done.
//    - Reset value 0.
//  Undefined: no PARITY state, no o_parity_err port. Frame is start+DATA_BITS+stop.
// TESTING (bit period = 16 ticks; bench drives i_tick every 4 clk, plus one run with
// baudrate_generator at F_CLOCK=50E6, BAUDRATE=9600)
//  1 Frame 0xA5, stop=1 -> one o_rx_done pulse, o_data=0xA5, o_frame_err=0.
//  2 i_rx low 4 ticks then high -> back to IDLE, no o_rx_done, o_data unchanged.
//  3 Frame 0x3C with stop bit 0 -> o_rx_done, o_data=0x3C, o_frame_err=1.
//    Next frame 0x81 with good stop -> o_frame_err=0.
//  4 0x55 then 0xFF back-to-back, no idle gap -> two strobes, o_data 0x55 then 0xFF.
//  5 i_reset pulse during bit 3 of 0x12 -> all outputs 0, no strobe.
//    Next frame 0x6E received correctly.
//  6 UART_RX_PARITY_EN: 0x07 + parity 1 -> o_parity_err=0;
//    0x07 + parity 0 -> o_parity_err=1; o_data=0x07 both.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, 8N1 by default.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line idle, waiting for a low level on the synchronized line
// START  | counting to the middle of the start bit, glitch check there
// DATA   | sampling DATA_BITS data bits at their centres, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN builds only)
// STOP   | waiting SB_TICKS ticks, then latch byte and status, strobe done
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int SAMPLING  = 16,
   parameter int SB_TICKS  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_rx_done,
`ifdef UART_RX_PARITY_EN
   output logic                 o_parity_err,
`endif
   output logic                 o_frame_err
);

   localparam int S_MAX = (SAMPLING > SB_TICKS) ? SAMPLING : SB_TICKS;
   localparam int SW    = $clog2(S_MAX);
   localparam int NW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SW-1:0] S_MID  = SW'(SAMPLING/2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(SAMPLING - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state, state_n;
   logic [SW-1:0]        s, s_n;
   logic [NW-1:0]        n, n_n;
   logic [DATA_BITS-1:0] b, b_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 done_n;
   logic                 frame_err_n;
   logic                 rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
   logic                 p, p_n;
   logic                 parity_err_n;
`endif

   // i_rx is asynchronous to i_clk; two flops before anything looks at it
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         o_data       <= '0;
         o_rx_done    <= 1'b0;
         o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         p            <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         s            <= s_n;
         n            <= n_n;
         b            <= b_n;
         o_data       <= data_n;
         o_rx_done    <= done_n;
         o_frame_err  <= frame_err_n;
`ifdef UART_RX_PARITY_EN
         p            <= p_n;
         o_parity_err <= parity_err_n;
`endif
      end
   end

   always_comb begin
      state_n      = state;
      s_n          = s;
      n_n          = n;
      b_n          = b;
      data_n       = o_data;
      done_n       = 1'b0;
      frame_err_n  = o_frame_err;
`ifdef UART_RX_PARITY_EN
      p_n          = p;
      parity_err_n = o_parity_err;
`endif

      case (state)
         IDLE: begin
            // entered on any cycle, not just ticks, so a start edge right
            // after a mid-stop-bit exit is still caught
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end

         START: begin
            if (i_tick) begin
               if (s == S_MID) begin
                  if (!rx_s) begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end

         DATA: begin
            if (i_tick) begin
               if (s == S_BIT) begin
                  s_n = '0;
                  b_n = {rx_s, b[DATA_BITS-1:1]};
                  if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     n_n = n + NW'(1);
                  end
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (i_tick) begin
               if (s == S_BIT) begin
                  s_n     = '0;
                  p_n     = rx_s;
                  state_n = STOP;
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end
`endif

         STOP: begin
            if (i_tick) begin
               if (s == S_STOP) begin
                  state_n     = IDLE;
                  data_n      = b;
                  frame_err_n = ~rx_s;
                  done_n      = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err_n = ^{b, p};
`endif
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, 16 ticks per bit (64 clk per bit).
// Parity vectors run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   logic       i_clk   = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_tick  = 1'b0;
   logic       i_rx    = 1'b1;
   logic [7:0] o_data;
   logic       o_rx_done;
   logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
   logic       o_parity_err;
   logic       cap_pe = 1'b0;
`endif

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_done  = 0;
   logic [7:0] cap_data = 8'h00;
   logic       cap_fe   = 1'b0;

   uart_rx dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_rx_done   (o_rx_done),
`ifdef UART_RX_PARITY_EN
      .o_parity_err(o_parity_err),
`endif
      .o_frame_err (o_frame_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge i_clk);
         i_tick = (c == 3);
         c = (c + 1) % 4;
      end
   end

   // done strobe monitor: counts pulses, captures the outputs presented with each
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_rx_done) begin
            n_done   = n_done + 1;
            cap_data = o_data;
            cap_fe   = o_frame_err;
`ifdef UART_RX_PARITY_EN
            cap_pe   = o_parity_err;
`endif
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int k);
      repeat (k) @(negedge i_clk);
   endtask

   task automatic drive_bit(input logic v);
      i_rx = v;
      wait_clk(BIT_CLK);
   endtask

   // a low stop bit is shortened so the re-armed start check sees the line high
   task automatic drive_stop(input logic stop);
      if (stop) begin
         drive_bit(1'b1);
      end else begin
         i_rx = 1'b0;
         wait_clk(44);
         i_rx = 1'b1;
         wait_clk(BIT_CLK - 44);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_stop(stop);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_p(input logic [7:0] d, input logic par);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(1'b1);
   endtask
`endif

   initial begin
      logic [7:0] v12;
      int         brk_low;

      wait_clk(3);
      chk("reset_data", o_data, 8'h00);
      chk("reset_done", o_rx_done, 1'b0);
      chk("reset_ferr", o_frame_err, 1'b0);
      i_reset = 1'b0;
      wait_clk(10);

      // 1: good frame
      send_frame(8'hA5, 1'b1);
      wait_clk(20);
      chk("a5_count", n_done, 1);
      chk("a5_data", cap_data, 8'hA5);
      chk("a5_ferr", cap_fe, 1'b0);

      // 2: short low glitch rejected
      i_rx = 1'b0;
      wait_clk(16);
      i_rx = 1'b1;
      wait_clk(200);
      chk("glitch_count", n_done, 1);
      chk("glitch_data", o_data, 8'hA5);

      // 3: bad stop bit, then recovery
      send_frame(8'h3C, 1'b0);
      wait_clk(20);
      chk("3c_count", n_done, 2);
      chk("3c_data", cap_data, 8'h3C);
      chk("3c_ferr", cap_fe, 1'b1);
      send_frame(8'h81, 1'b1);
      wait_clk(20);
      chk("81_count", n_done, 3);
      chk("81_data", cap_data, 8'h81);
      chk("81_ferr", cap_fe, 1'b0);

      // 4: back-to-back, no idle gap
      send_frame(8'h55, 1'b1);
      chk("b2b_55_count", n_done, 4);
      chk("b2b_55_data", cap_data, 8'h55);
      send_frame(8'hFF, 1'b1);
      wait_clk(20);
      chk("b2b_ff_count", n_done, 5);
      chk("b2b_ff_data", cap_data, 8'hFF);
      chk("b2b_ff_ferr", cap_fe, 1'b0);

      // 5: reset in the middle of bit 3 of 0x12
      v12 = 8'h12;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(v12[i]);
      i_rx = v12[3];
      wait_clk(32);
      i_reset = 1'b1;
      wait_clk(1);
      chk("rst_mid_data", o_data, 8'h00);
      chk("rst_mid_done", o_rx_done, 1'b0);
      chk("rst_mid_ferr", o_frame_err, 1'b0);
      wait_clk(2);
      i_reset = 1'b0;
      i_rx    = 1'b1;
      wait_clk(200);
      chk("rst_mid_count", n_done, 5);
      chk("rst_after_data", o_data, 8'h00);
      send_frame(8'h6E, 1'b1);
      wait_clk(20);
      chk("6e_count", n_done, 6);
      chk("6e_data", cap_data, 8'h6E);
      chk("6e_ferr", cap_fe, 1'b0);

      // break: one all-zero frame with framing error; released before the
      // re-entered start bit reaches its centre so no second frame follows
`ifdef UART_RX_PARITY_EN
      brk_low = 624 + BIT_CLK;
`else
      brk_low = 624;
`endif
      i_rx = 1'b0;
      wait_clk(brk_low);
      i_rx = 1'b1;
      wait_clk(20);
      chk("break_count", n_done, 7);
      chk("break_data", cap_data, 8'h00);
      chk("break_ferr", cap_fe, 1'b1);
      wait_clk(300);
      chk("break_after_count", n_done, 7);

`ifdef UART_RX_PARITY_EN
      // 6: even parity on 0x07 (three ones -> parity bit 1)
      send_frame_p(8'h07, 1'b1);
      wait_clk(20);
      chk("par_ok_count", n_done, 8);
      chk("par_ok_data", cap_data, 8'h07);
      chk("par_ok_perr", cap_pe, 1'b0);
      send_frame_p(8'h07, 1'b0);
      wait_clk(20);
      chk("par_bad_count", n_done, 9);
      chk("par_bad_data", cap_data, 8'h07);
      chk("par_bad_perr", cap_pe, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
